pio_cmd_receiver: RTL and testbench
===================================

Name: pio_cmd_receiver

Overview:
- FPGA-side receiving end of the HPS-to-coprocessor PIO command interface.
- Samples the instruction, window-position and window-dimension PIO words on a rising edge of the start PIO, then decodes and validates the command.
- Issues valid commands to the image engine with a valid/ready handshake, waits for engine completion, and drives the done PIO back to the HPS.
- Completion uses a four-phase handshake: done stays high until software drops start.

Parameters:
- IMG_W, 320, source image width in pixels; window bound check.
- IMG_H, 240, source image height in pixels; window bound check.
- TIMEOUT_CYC, 1000000, maximum cycles waiting for eng_done before a timeout error.
- CNT_W, 20, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; same domain as the PIOs.
- reset  in  1  synchronous, active-high.
- pio_instruct  in  32  bits [3:0] opcode, bits [31:4] argument.
- pio_janela_pos  in  32  bits [15:0] x, bits [31:16] y.
- pio_janela_dim  in  32  bits [15:0] w, bits [31:16] h.
- pio_start  in  1  command request level from HPS.
- pio_reset  in  1  software reset level from HPS.
- pio_done  out  1  completion flag to HPS.
- cmd_valid  out  1  command valid to engine.
- cmd_ready  in  1  engine accepts command.
- cmd_opcode  out  4  latched opcode.
- cmd_arg  out  28  latched argument.
- win_x, win_y, win_w, win_h  out  16 each  latched window.
- eng_done  in  1  single-cycle engine completion pulse.
- eng_rst  out  1  single-cycle engine reset pulse.
- status  out  3  result code of the last command.

Behaviour:
- Reset values: all outputs 0, state IDLE, start_q=0, status=0 (OK).
- pio_reset=1 acts as a synchronous reset of this block (same effect as reset) and asserts eng_rst for exactly one cycle on its rising edge.
  - While pio_reset is held, state stays IDLE.
  - Whenever reset or pio_reset is high, a pio_start edge is ignored.
- Start detect: start_q is registered pio_start; the rising edge is pio_start & ~start_q.
- Opcodes:
  - 0 NOP
  - 1 ZOOM_IN
  - 2 ZOOM_OUT
  - 3 SET_WINDOW
  - 4 RESTORE
  - 5..15 illegal
- Status codes:
  - 0 OK
  - 1 ILLEGAL_OP
  - 2 BAD_WINDOW
  - 3 TIMEOUT
- FSM:
  - IDLE: on rising edge at edge N, latch pio_instruct and both janela words into the cmd_*/win_* registers; go to CHECK. pio_done=0.
  - CHECK (one cycle):
    - opcode 0 → DONE, status OK.
    - opcode ≥5 → DONE, status ILLEGAL_OP.
    - opcode 3 with win_w==0, win_h==0, x+w>IMG_W or y+h>IMG_H → DONE, status BAD_WINDOW. Sums are computed at 17 bits, so there is no wraparound.
    - Otherwise → ISSUE.
  - ISSUE: cmd_valid=1, held with stable cmd_* until a cycle with cmd_ready=1; then cmd_valid drops on the next edge and the FSM goes to WAIT with the timeout counter cleared.
    - cmd_valid first asserts at edge N+2.
  - WAIT: counter increments each cycle.
    - eng_done=1 → DONE, status OK.
    - Counter reaches TIMEOUT_CYC-1 without eng_done → DONE, status TIMEOUT, and eng_rst pulses one cycle.
    - If eng_done and the timeout coincide, eng_done wins (OK).
  - DONE: pio_done=1.
    - Stays until pio_start==0, then IDLE with pio_done=0 on the next edge.
    - If start is already low on DONE entry, pio_done is still high for at least one cycle.
- Latched cmd_* and win_* hold their values until the next accepted start. status holds until the next CHECK.
- pio_instruct and janela changes outside the IDLE latch edge are ignored.
- A start rising edge outside IDLE is ignored: no queueing, and start_q still tracks.
- eng_done in any state other than WAIT is ignored.
- Reset mid-operation (any state) → IDLE next edge, cmd_valid=0, pio_done=0.

Test Plan:
- ZOOM_IN: instruct=0x00000001, start 0→1; cmd_ready=1 immediately → cmd_valid high exactly one cycle at N+2; eng_done 5 cycles later → pio_done=1, status=0; start→0 → pio_done=0 one cycle later.
- SET_WINDOW: opcode 3, pos x=300 y=0, dim w=21 h=10 (x+w=321) → no cmd_valid, pio_done=1, status=2. Repeat with w=20 → issued, status=0 after eng_done.
- Illegal opcode 0xF → pio_done=1 within 2 cycles of start, status=1, cmd_valid never high. NOP → status=0, no cmd_valid.
- Backpressure: cmd_ready low 7 cycles → cmd_valid and cmd_opcode stable throughout; handshake completes on cycle 8. Change pio_instruct during this wait → cmd_opcode unchanged.
- Timeout with TIMEOUT_CYC=16: no eng_done → DONE exactly 16 cycles after entering WAIT, status=3, eng_rst one-cycle pulse. Variant: eng_done on the final cycle → status=0, no eng_rst.
- pio_reset asserted during WAIT → eng_rst one pulse, pio_done=0, IDLE. Holding start high across release produces no new command until start toggles low then high.

Source files
------------

// File: rtl/pio_cmd_receiver.sv
// pio_cmd_receiver: HPS PIO command intake, validation and engine handshake.
// Done is a four-phase flag; it clears only after software drops start.
module pio_cmd_receiver #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int CNT_W       = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pio_instruct,
  input  logic [31:0] pio_janela_pos,
  input  logic [31:0] pio_janela_dim,
  input  logic        pio_start,
  input  logic        pio_reset,
  output logic        pio_done,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_opcode,
  output logic [27:0] cmd_arg,
  output logic [15:0] win_x,
  output logic [15:0] win_y,
  output logic [15:0] win_w,
  output logic [15:0] win_h,
  input  logic        eng_done,
  output logic        eng_rst,
  output logic [2:0]  status
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [2:0] ST_OK   = 3'd0;
  localparam logic [2:0] ST_ILL  = 3'd1;
  localparam logic [2:0] ST_BAD  = 3'd2;
  localparam logic [2:0] ST_TOUT = 3'd3;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_WIN = 4'd3;
  localparam logic [3:0] OP_MAX = 4'd4;

  localparam logic [16:0] IMG_W17 = 17'(IMG_W);
  localparam logic [16:0] IMG_H17 = 17'(IMG_H);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic             start_q;
  logic             prst_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [27:0]      arg_q, arg_d;
  logic [15:0]      x_q, x_d;
  logic [15:0]      y_q, y_d;
  logic [15:0]      w_q, w_d;
  logic [15:0]      h_q, h_d;
  logic [2:0]       status_q, status_d;
  logic             eng_rst_q, eng_rst_d;

  logic             rise;
  logic [16:0]      x_end;
  logic [16:0]      y_end;
  logic             bad_win;

  assign rise  = pio_start & ~start_q;
  assign x_end = {1'b0, x_q} + {1'b0, w_q};
  assign y_end = {1'b0, y_q} + {1'b0, h_q};

  assign bad_win = (w_q == 16'd0) | (h_q == 16'd0) |
                   (x_end > IMG_W17) | (y_end > IMG_H17);

  // next-state, latch and status decisions; software reset overrides all
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    arg_d     = arg_q;
    x_d       = x_q;
    y_d       = y_q;
    w_d       = w_q;
    h_d       = h_q;
    status_d  = status_q;
    eng_rst_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rise) begin
          op_d    = pio_instruct[3:0];
          arg_d   = pio_instruct[31:4];
          x_d     = pio_janela_pos[15:0];
          y_d     = pio_janela_pos[31:16];
          w_d     = pio_janela_dim[15:0];
          h_d     = pio_janela_dim[31:16];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (op_q == OP_NOP) begin
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (op_q > OP_MAX) begin
          status_d = ST_ILL;
          state_d  = S_DONE;
        end else if ((op_q == OP_WIN) && bad_win) begin
          status_d = ST_BAD;
          state_d  = S_DONE;
        end else begin
          status_d = ST_OK;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (cmd_ready) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (eng_done) begin
          status_d = ST_OK;
          state_d  = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          status_d  = ST_TOUT;
          eng_rst_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (!pio_start) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (pio_reset) begin
      state_d   = S_IDLE;
      cnt_d     = '0;
      op_d      = '0;
      arg_d     = '0;
      x_d       = '0;
      y_d       = '0;
      w_d       = '0;
      h_d       = '0;
      status_d  = ST_OK;
      eng_rst_d = ~prst_q;
    end
  end

  // state and datapath registers; start/pio_reset history keeps tracking
  // under software reset so a held start never looks like a fresh edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      prst_q    <= 1'b0;
      cnt_q     <= '0;
      op_q      <= '0;
      arg_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      w_q       <= '0;
      h_q       <= '0;
      status_q  <= ST_OK;
      eng_rst_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      start_q   <= pio_start;
      prst_q    <= pio_reset;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      arg_q     <= arg_d;
      x_q       <= x_d;
      y_q       <= y_d;
      w_q       <= w_d;
      h_q       <= h_d;
      status_q  <= status_d;
      eng_rst_q <= eng_rst_d;
    end
  end

  assign pio_done   = (state_q == S_DONE);
  assign cmd_valid  = (state_q == S_ISSUE);
  assign cmd_opcode = op_q;
  assign cmd_arg    = arg_q;
  assign win_x      = x_q;
  assign win_y      = y_q;
  assign win_w      = w_q;
  assign win_h      = h_q;
  assign status     = status_q;
  assign eng_rst    = eng_rst_q;

endmodule

// File: tb/tb_pio_cmd_receiver.sv
// tb_pio_cmd_receiver: directed scenarios plus random traffic against a
// timestamp-based command model, compared every cycle.
module tb_pio_cmd_receiver;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pio_instruct = '0;
  logic [31:0] pio_janela_pos = '0;
  logic [31:0] pio_janela_dim = '0;
  logic        pio_start = 1'b0;
  logic        pio_reset = 1'b0;
  logic        pio_done;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic [3:0]  cmd_opcode;
  logic [27:0] cmd_arg;
  logic [15:0] win_x, win_y, win_w, win_h;
  logic        eng_done = 1'b0;
  logic        eng_rst;
  logic [2:0]  status;

  pio_cmd_receiver #(
    .IMG_W(320), .IMG_H(240), .TIMEOUT_CYC(TO), .CNT_W(5)
  ) dut (
    .clk(clk), .reset(reset),
    .pio_instruct(pio_instruct),
    .pio_janela_pos(pio_janela_pos),
    .pio_janela_dim(pio_janela_dim),
    .pio_start(pio_start), .pio_reset(pio_reset),
    .pio_done(pio_done), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_arg(cmd_arg), .win_x(win_x), .win_y(win_y),
    .win_w(win_w), .win_h(win_h), .eng_done(eng_done),
    .eng_rst(eng_rst), .status(status)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // outcome of a command from its fields alone: status code, or -1 = issue
  function automatic int classify(int op, int x, int y, int w, int h);
    if (op == 0) return 0;
    if (op >= 5) return 1;
    if (op == 3 && (w == 0 || h == 0 || x + w > 320 || y + h > 240))
      return 2;
    return -1;
  endfunction

  // model: one command at a time, tracked by edge timestamps
  int t = 0;
  bit busy = 0;
  int acc_t = 0, hs_t = -1, done_t = -1, verdict = 0;
  bit m_sq = 0, m_prst = 0, m_er = 0, m_valid = 0, m_done = 0;
  logic [3:0]  m_op = '0;
  logic [27:0] m_arg = '0;
  logic [15:0] m_x = '0, m_y = '0, m_w = '0, m_h = '0;
  logic [2:0]  m_st = '0;

  always @(posedge clk) begin
    t++;
    m_er = 0;
    if (reset || pio_reset) begin
      if (!reset && !m_prst) m_er = 1;
      busy = 0;
      m_op = '0; m_arg = '0;
      m_x = '0; m_y = '0; m_w = '0; m_h = '0;
      m_st = '0;
    end else if (!busy) begin
      if (pio_start && !m_sq) begin
        m_op  = pio_instruct[3:0];
        m_arg = pio_instruct[31:4];
        m_x   = pio_janela_pos[15:0];
        m_y   = pio_janela_pos[31:16];
        m_w   = pio_janela_dim[15:0];
        m_h   = pio_janela_dim[31:16];
        busy  = 1;
        acc_t = t;
        hs_t  = -1;
        done_t = -1;
        verdict = classify(int'(m_op), int'(m_x), int'(m_y),
                           int'(m_w), int'(m_h));
      end
    end else begin
      if (t == acc_t + 1) begin
        m_st = (verdict < 0) ? 3'd0 : 3'(verdict);
        if (verdict >= 0) done_t = t;
      end else if (done_t >= 0) begin
        if (!pio_start) busy = 0;
      end else if (hs_t < 0) begin
        if (cmd_ready) hs_t = t;
      end else if (eng_done) begin
        done_t = t;
        m_st = 3'd0;
      end else if (t - hs_t == TO) begin
        done_t = t;
        m_st = 3'd3;
        m_er = 1;
      end
    end
    m_sq   = reset ? 1'b0 : pio_start;
    m_prst = reset ? 1'b0 : pio_reset;
    m_valid = busy && verdict < 0 && hs_t < 0 && t >= acc_t + 1;
    m_done  = busy && done_t >= 0;
  end

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pio_done", 32'(pio_done), 32'(m_done));
      chk("cmd_valid", 32'(cmd_valid), 32'(m_valid));
      chk("eng_rst", 32'(eng_rst), 32'(m_er));
      chk("status", 32'(status), 32'(m_st));
      chk("cmd_opcode", 32'(cmd_opcode), 32'(m_op));
      chk("cmd_arg", 32'(cmd_arg), 32'(m_arg));
      chk("win_x", 32'(win_x), 32'(m_x));
      chk("win_y", 32'(win_y), 32'(m_y));
      chk("win_w", 32'(win_w), 32'(m_w));
      chk("win_h", 32'(win_h), 32'(m_h));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    repeat (3) tick();
    chk_en = 1;
    reset = 0;
    tick();
    chk("rst_done", 32'(pio_done), 0);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_status", 32'(status), 0);

    // ZOOM_IN with immediate ready
    pio_instruct = 32'h0000_0001; pio_start = 1; cmd_ready = 1;
    tick(); tick();
    chk("zi_valid", 32'(cmd_valid), 1);
    tick();
    chk("zi_valid_drop", 32'(cmd_valid), 0);
    repeat (4) tick();
    eng_done = 1; tick(); eng_done = 0;
    chk("zi_done", 32'(pio_done), 1);
    chk("zi_status", 32'(status), 0);
    pio_start = 0; tick();
    chk("zi_done_clr", 32'(pio_done), 0);

    // SET_WINDOW out of bounds, then in bounds
    pio_instruct = 32'h0000_0003;
    pio_janela_pos = {16'd0, 16'd300};
    pio_janela_dim = {16'd10, 16'd21};
    pio_start = 1; tick(); tick();
    chk("win_bad_done", 32'(pio_done), 1);
    chk("win_bad_status", 32'(status), 2);
    chk("win_bad_valid", 32'(cmd_valid), 0);
    pio_start = 0; tick();
    pio_janela_dim = {16'd10, 16'd20};
    pio_start = 1; tick(); tick();
    chk("win_ok_valid", 32'(cmd_valid), 1);
    tick(); eng_done = 1; tick(); eng_done = 0;
    chk("win_ok_status", 32'(status), 0);
    chk("win_ok_done", 32'(pio_done), 1);
    pio_start = 0; tick();

    // illegal opcode and NOP
    pio_instruct = 32'hABCD_123F; pio_start = 1; tick(); tick();
    chk("ill_done", 32'(pio_done), 1);
    chk("ill_status", 32'(status), 1);
    pio_start = 0; tick();
    pio_instruct = 32'h0000_0010; pio_start = 1; tick(); tick();
    chk("nop_done", 32'(pio_done), 1);
    chk("nop_status", 32'(status), 0);
    pio_start = 0; tick();

    // backpressure then timeout
    pio_instruct = 32'h0000_0002; cmd_ready = 0; pio_start = 1;
    tick(); tick();
    pio_instruct = 32'h0000_0004;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_valid", 32'(cmd_valid), 1);
      chk("bp_opcode", 32'(cmd_opcode), 2);
    end
    cmd_ready = 1; tick(); cmd_ready = 0;
    chk("bp_hs", 32'(cmd_valid), 0);
    k = 0;
    do begin tick(); k++; end while (!pio_done && k < 40);
    chk("to_cycles", 32'(k), 16);
    chk("to_status", 32'(status), 3);
    chk("to_rst", 32'(eng_rst), 1);
    tick();
    chk("to_rst_drop", 32'(eng_rst), 0);
    pio_start = 0; tick();

    // eng_done on the last cycle beats the timeout
    pio_instruct = 32'h0000_0001; cmd_ready = 1; pio_start = 1;
    tick(); tick(); tick();
    repeat (15) tick();
    chk("late_not_done", 32'(pio_done), 0);
    eng_done = 1; tick(); eng_done = 0;
    chk("late_done", 32'(pio_done), 1);
    chk("late_status", 32'(status), 0);
    chk("late_rst", 32'(eng_rst), 0);
    pio_start = 0; tick();

    // software reset during WAIT with start held high
    pio_start = 1; tick(); tick(); tick();
    repeat (3) tick();
    pio_reset = 1; tick();
    chk("sr_rst", 32'(eng_rst), 1);
    chk("sr_done", 32'(pio_done), 0);
    tick();
    chk("sr_rst_drop", 32'(eng_rst), 0);
    pio_reset = 0;
    repeat (4) begin
      tick();
      chk("sr_no_cmd", 32'(cmd_valid), 0);
    end
    pio_start = 0; tick();
    pio_start = 1; tick(); tick();
    chk("sr_new_cmd", 32'(cmd_valid), 1);
    tick(); eng_done = 1; tick(); eng_done = 0;
    chk("sr_new_done", 32'(pio_done), 1);
    pio_start = 0; tick();

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      reset = ($urandom_range(0, 499) == 0);
      if (pio_reset) pio_reset = ($urandom_range(0, 1) == 0);
      else pio_reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0) pio_start = ~pio_start;
      cmd_ready = ($urandom_range(0, 1) == 0);
      eng_done = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0)
        pio_instruct = {$urandom(), 4'($urandom_range(0, 15))};
      else
        pio_instruct = {$urandom(), 4'($urandom_range(0, 4))};
      if ($urandom_range(0, 7) == 0) begin
        pio_janela_pos = $urandom();
        pio_janela_dim = $urandom();
      end else begin
        pio_janela_pos = {16'($urandom_range(0, 250)),
                          16'($urandom_range(0, 330))};
        pio_janela_dim = {16'($urandom_range(0, 40)),
                          16'($urandom_range(0, 40))};
      end
    end
    tick();
    reset = 0; pio_reset = 0; pio_start = 0;
    cmd_ready = 1; eng_done = 1;
    repeat (5) tick();
    chk("end_idle", 32'(pio_done), 0);
    eng_done = 0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
